// File: rtl/log_fxp_pkg.sv
// Shared widths, constants and stage types for the log-to-linear pipeline.
// Macro LOG_ANTILOG_CORR_EN adds the Mitchell-error correction table.
package log_fxp_pkg;

  localparam int LOG_W      = 16;
  localparam int LOG_FRAC_W = 12;
  localparam int OUT_W      = 16;
  localparam int OUT_FRAC_W = 14;
  localparam int MANT_W     = OUT_FRAC_W + 1;

  localparam logic [MANT_W-1:0] SAT_MAG = 15'h7FFF;

`ifdef LOG_ANTILOG_CORR_EN
  // round(16384 * (1 + m - 2^m)) with m = (k + 0.5) / 8
  localparam logic [MANT_W-1:0] CORR_TABLE [8] = '{
    15'd299, 15'd798, 15'd1157, 15'd1364, 15'd1404, 15'd1262, 15'd922, 15'd365
  };
`endif

  typedef struct packed {
    logic                  valid;
    logic                  zero;
    logic                  sat;
    logic                  sign;
    logic [3:0]            shift;
    logic [LOG_FRAC_W-1:0] frac;
    logic [MANT_W-1:0]     corr;
  } s1_t;

  typedef struct packed {
    logic              valid;
    logic              zero;
    logic              sat;
    logic              sign;
    logic [3:0]        shift;
    logic [MANT_W-1:0] mant;
  } s2_t;

endpackage

// File: rtl/antilog_corr_rom.sv
// Combinational 8-entry Mitchell correction lookup, indexed by the top fraction bits.
// Only present when LOG_ANTILOG_CORR_EN is defined.
`ifdef LOG_ANTILOG_CORR_EN
module antilog_corr_rom
  import log_fxp_pkg::*;
(
  input  logic [2:0]        idx_i,
  output logic [MANT_W-1:0] corr_o
);

  assign corr_o = CORR_TABLE[idx_i];

endmodule
`endif

// File: rtl/log_antilog_pipe.sv
// Three-stage signed Q4.12 log2 -> Q2.14 linear converter with valid/ready stall.
// LOG_ANTILOG_CORR_EN enables the correction table between S1 and S2.
module log_antilog_pipe #(
  parameter int LOG_W      = log_fxp_pkg::LOG_W,
  parameter int LOG_FRAC_W = log_fxp_pkg::LOG_FRAC_W,
  parameter int OUT_W      = log_fxp_pkg::OUT_W,
  parameter int OUT_FRAC_W = log_fxp_pkg::OUT_FRAC_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [LOG_W-1:0] in_log,
  input  logic             in_sign,
  input  logic             in_zero,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_sat
);
  import log_fxp_pkg::*;

  localparam logic [OUT_FRAC_W:0] MANT_ONE = {1'b1, {OUT_FRAC_W{1'b0}}};

  s1_t               s1_d, s1_q;
  s2_t               s2_d, s2_q;
  logic              out_valid_q;
  logic              out_sat_d, out_sat_q;
  logic [OUT_W-1:0]  out_data_d, out_data_q;
  logic              adv_s;
  logic [3:0]        int_s;
  logic [MANT_W-1:0] corr_s;
  logic [MANT_W-1:0] mag_s;

  // Whole pipe moves together; bubbles stay in place.
  assign adv_s    = !out_valid_q || out_ready;
  assign in_ready = adv_s;
  assign int_s    = in_log[LOG_W-1:LOG_FRAC_W];

`ifdef LOG_ANTILOG_CORR_EN
  antilog_corr_rom u_corr_rom (
    .idx_i  (in_log[LOG_FRAC_W-1 -: 3]),
    .corr_o (corr_s)
  );
`else
  assign corr_s = '0;
`endif

  always_comb begin
    s1_d.valid = in_valid;
    s1_d.zero  = in_zero;
    s1_d.sat   = !in_zero && !int_s[3] && (int_s != 4'd0);
    s1_d.sign  = in_sign;
    s1_d.shift = 4'd0 - int_s;  // -i in 0..8 whenever i <= 0
    s1_d.frac  = in_log[LOG_FRAC_W-1:0];
    s1_d.corr  = corr_s;
  end

  always_comb begin
    s2_d.valid = s1_q.valid;
    s2_d.zero  = s1_q.zero;
    s2_d.sat   = s1_q.sat;
    s2_d.sign  = s1_q.sign;
    s2_d.shift = s1_q.shift;
    s2_d.mant  = MANT_ONE + {1'b0, s1_q.frac, 2'b00} - s1_q.corr;
  end

  always_comb begin
    mag_s     = s2_q.sat ? SAT_MAG : (s2_q.mant >> s2_q.shift);
    out_sat_d = s2_q.sat;
    if (s2_q.zero) begin
      out_data_d = '0;
    end else if (s2_q.sign) begin
      out_data_d = {OUT_W{1'b0}} - {1'b0, mag_s};
    end else begin
      out_data_d = {1'b0, mag_s};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q        <= '0;
      s2_q        <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
    end else if (adv_s) begin
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      out_valid_q <= s2_q.valid;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_log_antilog_pipe.sv
// Self-checking bench for log_antilog_pipe: directed vectors, random stream with
// backpressure, full throughput and mid-stream reset against an arithmetic model.
module tb_log_antilog_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_sign, in_zero;
  logic [15:0] in_log;
  logic        out_valid, out_ready, out_sat;
  logic [15:0] out_data;

  int n_checks = 0;
  int n_pass   = 0;
  logic [16:0] exp_q[$];

  always #5 clk = ~clk;

  log_antilog_pipe dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_log(in_log),
    .in_sign(in_sign), .in_zero(in_zero),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sat(out_sat)
  );

  function automatic int corr_val(int k);
`ifdef LOG_ANTILOG_CORR_EN
    real m;
    m = (real'(k) + 0.5) / 8.0;
    return int'($floor(16384.0 * (1.0 + m - 2.0 ** m) + 0.5));
`else
    return k * 0;
`endif
  endfunction

  // Returns {sat, data} from the real-valued conversion rules.
  function automatic logic [16:0] model(logic [15:0] lg, logic sg, logic z);
    int ip, f, mag;
    logic sat;
    ip  = int'($signed(lg[15:12]));
    f   = int'(lg[11:0]);
    sat = 1'b0;
    if (z) return 17'd0;
    if (ip >= 1) begin
      mag = 32767;
      sat = 1'b1;
    end else begin
      mag = (16384 + 4 * f - corr_val(f / 512)) / (1 << (-ip));
    end
    if (sg) mag = -mag;
    return {sat, mag[15:0]};
  endfunction

  // One clock: sample handshake state just before the edge, then advance.
  task automatic step(output logic fired, output logic ov, output logic [15:0] d,
                      output logic s, output logic acc, output logic ir);
    #1;
    acc   = in_valid && in_ready;
    fired = out_valid && out_ready;
    ov    = out_valid;
    d     = out_data;
    s     = out_sat;
    ir    = in_ready;
    if (acc) exp_q.push_back(model(in_log, in_sign, in_zero));
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_log = '0; in_sign = 1'b0; in_zero = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", out_valid); else n_pass++;
    n_checks++; if (out_data !== 16'd0) $display("FAIL reset_data: got %h want 0000", out_data); else n_pass++;
    n_checks++; if (out_sat !== 1'b0) $display("FAIL reset_sat: got %b want 0", out_sat); else n_pass++;
    rst = 1'b0;
    #1;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else n_pass++;
  endtask

  task automatic test_directed();
    logic [15:0] logs[8] = '{16'hF800, 16'hF800, 16'h8000, 16'h0800, 16'h1000, 16'h1234, 16'h7FFF, 16'hFFFF};
    logic        sgns[8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic        zers[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic        sats[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
`ifdef LOG_ANTILOG_CORR_EN
    int exp_d[8] = '{11586, -11586, 62, 23172, -32767, 0, 32767, 16199};
`else
    int exp_d[8] = '{12288, -12288, 64, 24576, -32767, 0, 32767, 16382};
`endif
    logic f, ov, s, a, ir, got;
    logic [15:0] d;
    logic [16:0] e;
    int n;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_log = logs[i]; in_sign = sgns[i]; in_zero = zers[i]; in_valid = 1'b1;
      step(f, ov, d, s, a, ir);
      in_valid = 1'b0;
      n_checks++; if (a !== 1'b1) $display("FAIL dir_accept[%0d]: got %b want 1", i, a); else n_pass++;
      n = 0; got = 1'b0;
      while (!got && n < 10) begin
        step(f, ov, d, s, a, ir);
        n++;
        got = f;
      end
      n_checks++; if (n !== 3) $display("FAIL dir_latency[%0d]: got %0d want 3", i, n); else n_pass++;
      n_checks++; if (d !== 16'(exp_d[i])) $display("FAIL dir_data[%0d]: got %h want %h", i, d, 16'(exp_d[i])); else n_pass++;
      n_checks++; if (s !== sats[i]) $display("FAIL dir_sat[%0d]: got %b want %b", i, s, sats[i]); else n_pass++;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 17'h1FFFF;
      n_checks++; if ({s, d} !== e) $display("FAIL dir_model[%0d]: got %h want %h", i, {s, d}, e); else n_pass++;
    end
  endtask

  task automatic test_random();
    logic f, ov, s, a, ir, prev_stall;
    logic [15:0] d, prev_d;
    logic prev_s;
    logic [16:0] e;
    int sent, rcvd, cyc;
    sent = 0; rcvd = 0; cyc = 0; prev_stall = 1'b0; prev_d = '0; prev_s = 1'b0;
    in_valid = 1'b0;
    while (rcvd < 40 && cyc < 2000) begin
      if (!in_valid && sent < 40 && $urandom_range(3) != 0) begin
        in_valid = 1'b1; in_log = 16'($urandom); in_sign = 1'($urandom);
        in_zero = ($urandom_range(7) == 0);
      end
      out_ready = ($urandom_range(3) != 0);
      step(f, ov, d, s, a, ir);
      if (prev_stall) begin
        n_checks++; if ({ov, s, d} !== {1'b1, prev_s, prev_d}) $display("FAIL rnd_stable: got %b/%h want 1/%h", ov, {s, d}, {prev_s, prev_d}); else n_pass++;
      end
      if (ov && !out_ready) begin
        n_checks++; if (ir !== 1'b0) $display("FAIL rnd_in_ready_stall: got %b want 0", ir); else n_pass++;
      end
      prev_stall = ov && !out_ready; prev_d = d; prev_s = s;
      if (a) begin sent++; in_valid = 1'b0; end
      if (f) begin
        rcvd++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 17'h1FFFF;
        n_checks++; if ({s, d} !== e) $display("FAIL rnd_data[%0d]: got %h want %h", rcvd, {s, d}, e); else n_pass++;
      end
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n_checks++; if (rcvd !== 40) $display("FAIL rnd_count: got %0d want 40", rcvd); else n_pass++;
  endtask

  task automatic test_backpressure();
    logic f, ov, s, a, ir;
    logic [15:0] d, held_d;
    logic [16:0] e;
    int sent, rcvd, cyc;
    sent = 0; rcvd = 0; cyc = 0; held_d = '0;
    while (rcvd < 10 && cyc < 100) begin
      if (!in_valid && sent < 10) begin
        in_valid = 1'b1; in_log = 16'($urandom); in_sign = 1'($urandom); in_zero = 1'b0;
      end
      out_ready = !(cyc >= 6 && cyc < 11);
      step(f, ov, d, s, a, ir);
      if (cyc == 6) held_d = d;
      if (cyc >= 6 && cyc < 11) begin
        n_checks++; if (ir !== 1'b0) $display("FAIL bp_in_ready[%0d]: got %b want 0", cyc, ir); else n_pass++;
        n_checks++; if (d !== held_d || ov !== 1'b1) $display("FAIL bp_stable[%0d]: got %h/%b want %h/1", cyc, d, ov, held_d); else n_pass++;
      end
      if (a) begin sent++; in_valid = (sent < 10); if (sent < 10) begin in_log = 16'($urandom); in_sign = 1'($urandom); end end
      if (f) begin
        rcvd++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 17'h1FFFF;
        n_checks++; if ({s, d} !== e) $display("FAIL bp_data[%0d]: got %h want %h", rcvd, {s, d}, e); else n_pass++;
      end
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n_checks++; if (rcvd !== 10 || exp_q.size() !== 0) $display("FAIL bp_count: got %0d/%0d want 10/0", rcvd, exp_q.size()); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic f, ov, s, a, ir;
    logic [15:0] d;
    logic [16:0] e;
    int sent, rcvd, first_cyc, last_cyc;
    sent = 0; rcvd = 0; first_cyc = -1; last_cyc = -1;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      in_valid = (sent < 32);
      in_log = 16'($urandom); in_sign = 1'($urandom); in_zero = ($urandom_range(9) == 0);
      step(f, ov, d, s, a, ir);
      if (a) sent++;
      n_checks++; if (ir !== 1'b1) $display("FAIL b2b_in_ready[%0d]: got %b want 1", cyc, ir); else n_pass++;
      if (f) begin
        rcvd++;
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 17'h1FFFF;
        n_checks++; if ({s, d} !== e) $display("FAIL b2b_data[%0d]: got %h want %h", rcvd, {s, d}, e); else n_pass++;
      end
    end
    in_valid = 1'b0;
    n_checks++; if (rcvd !== 32) $display("FAIL b2b_count: got %0d want 32", rcvd); else n_pass++;
    n_checks++; if (first_cyc !== 3) $display("FAIL b2b_fill: got %0d want 3", first_cyc); else n_pass++;
    n_checks++; if (last_cyc - first_cyc !== 31) $display("FAIL b2b_rate: got %0d want 31", last_cyc - first_cyc); else n_pass++;
  endtask

  task automatic test_reset_midstream();
    logic f, ov, s, a, ir, stale;
    logic [15:0] d;
    int n;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_log = 16'($urandom); in_sign = 1'($urandom); in_zero = 1'b0;
      step(f, ov, d, s, a, ir);
    end
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1) $display("FAIL rstm_pre_valid: got %b want 1", out_valid); else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_checks++; if ({out_valid, out_sat, out_data} !== 18'd0) $display("FAIL rstm_drop: got %b/%b/%h want 0/0/0000", out_valid, out_sat, out_data); else n_pass++;
    exp_q.delete();
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL rstm_in_ready: got %b want 1", in_ready); else n_pass++;
    stale = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(f, ov, d, s, a, ir);
      stale = stale | ov;
    end
    n_checks++; if (stale !== 1'b0) $display("FAIL rstm_stale: got %b want 0", stale); else n_pass++;
    in_valid = 1'b1; in_log = 16'h0800; in_sign = 1'b1; in_zero = 1'b0;
    step(f, ov, d, s, a, ir);
    in_valid = 1'b0;
    n = 0; f = 1'b0;
    while (!f && n < 10) begin
      step(f, ov, d, s, a, ir);
      n++;
    end
    n_checks++; if (n !== 3) $display("FAIL rstm_latency: got %0d want 3", n); else n_pass++;
`ifdef LOG_ANTILOG_CORR_EN
    n_checks++; if (d !== 16'(-23172)) $display("FAIL rstm_data: got %h want %h", d, 16'(-23172)); else n_pass++;
`else
    n_checks++; if (d !== 16'(-24576)) $display("FAIL rstm_data: got %h want %h", d, 16'(-24576)); else n_pass++;
`endif
    void'(exp_q.pop_front());
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_midstream();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed so far", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/log_antilog_pipe.md
# log_antilog_pipe

Pipelined log-to-linear (antilog) converter. It takes the signed Q4.12 log2-domain values produced by the log-sin/log-cos lookup path and by the log-domain accumulations of the functional-link filter, and turns them back into signed linear fixed-point samples. It sits at the output of the log-domain datapath, ahead of error computation and weight update. A valid/ready handshake on both sides lets it stall under downstream backpressure.

## Interface
Parameters:
- LOG_W, 16, log-domain input width, signed Q4.12 (log2 units; -0.5 = 0xF800).
- LOG_FRAC_W, 12, fractional bits of the log input.
- OUT_W, 16, linear output width, signed Q2.14.
- OUT_FRAC_W, 14, fractional bits of the linear output.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  block accepts the input word this cycle.
- in_log  in  LOG_W  log2 of the magnitude, two's complement Q4.12.
- in_sign  in  1  sign of the linear value (1 = negative).
- in_zero  in  1  linear value is exactly zero; in_log is ignored.
- out_valid  out  1  output word valid.
- out_ready  in  1  downstream accepts the output word.
- out_data  out  OUT_W  signed Q2.14 linear result.
- out_sat  out  1  result was clipped to full scale.

## Operation
- Decomposition: i = in_log[15:12] (signed, range -8..7, equal to floor of the log value); f = in_log[11:0] (unsigned fraction).
- Mantissa (Q1.14, 15-bit unsigned) = 16384 + (f << 2), using the Mitchell approximation 2^f ≈ 1 + f.
- Magnitude:
  - i ≥ 1: magnitude = 0x7FFF and out_sat = 1.
  - i ≤ 0: magnitude = mantissa >> (−i), truncated. −i is 0..8, so the result never underflows to a negative shift.
- Sign: if in_sign = 1, out_data = −magnitude (two's complement); otherwise out_data = +magnitude. A saturated negative result is −0x7FFF, never 0x8000.
- in_zero = 1: out_data = 0, out_sat = 0. in_sign and in_log are ignored.
- Three pipeline stages:
  - S1: decompose, evaluate zero/saturation flags, correction lookup.
  - S2: form mantissa and apply correction.
  - S3: barrel shift, apply sign, register outputs.
- Single global advance enable: adv = !out_valid || out_ready. in_ready = adv.
- Each stage carries a valid bit. Bubbles are not collapsed.

## Timing
- Latency is 3 cycles from input acceptance (in_valid && in_ready) to out_valid, when there is no stall.
- Throughput is one word per cycle while out_ready = 1.
- When out_valid = 1 and out_ready = 0:
  - All stages hold.
  - out_data and out_sat stay stable.
  - in_ready = 0.
- in_ready is combinational from out_valid and out_ready only; it does not depend on in_valid.
- Reset (asynchronous, any time, including mid-stream):
  - All stage valid bits clear; in-flight words are dropped.
  - out_valid = 0, out_data = 0, out_sat = 0.
  - in_ready = 1 in the first cycle after reset deasserts.
- Simultaneous output consume and new input acceptance in the same cycle is legal and required for full throughput.

## Configuration
- LOG_ANTILOG_CORR_EN defined:
  - S1 looks up an 8-entry correction table indexed by f[11:9].
  - S2 subtracts the entry from the mantissa.
  - Each entry is round(16384·(1 + m − 2^m)) with m = (k + 0.5)/8; for example, entry 4 = 1404.
- Undefined: pure Mitchell mantissa, no table.
- Latency and handshake are identical in both builds.

## Structure
- Package log_fxp_pkg holds:
  - LOG_W, LOG_FRAC_W, OUT_W, OUT_FRAC_W.
  - The saturation constant 0x7FFF.
  - The 8-entry correction table as a localparam array, guarded by LOG_ANTILOG_CORR_EN.
- Sub-module antilog_corr_rom: combinational 3-bit → 15-bit correction lookup, instantiated only when the macro is defined.

## Test plan
- Basic conversion: in_log = 0xF800, sign 0, macro off → out_data = 12288 (0x3000) after 3 cycles. With macro on → 11586.
- Sign and integer part: in_log = 0xF800, sign 1, macro off → 0xD000. in_log = 0x8000 (−8.0) → 64. in_log = 0x0800 → 24576, out_sat = 0.
- Saturation and zero: in_log = 0x1000 (+1.0), sign 1 → −32767 (0x8001), out_sat = 1. in_zero = 1 with any in_log → 0, out_sat = 0.
- Backpressure: stream 10 words and hold out_ready = 0 for 5 cycles mid-stream → no loss or duplication, output order preserved, out_data stable while stalled, in_ready = 0 during the stall.
- Full throughput: in_valid = 1 and out_ready = 1 continuously for 32 words → one output per cycle after the 3-cycle fill.
- Reset mid-stream: assert rst with 3 words in flight → out_valid drops immediately. After release, the next word appears 3 cycles after acceptance, with no stale output.
